scarv_cop_insn_seq: RTL and testbench
=====================================

// Module: scarv_cop_insn_seq
// PURPOSE
//  Instruction sequencer for the SCARV coprocessor. Accepts one instruction at a time from the host
//  CPU, dispatches it to exactly one of NFU functional units and collects that unit's completion.
//  Commits the CPR write and returns a 3-bit result code plus optional GPR write-back to the CPU.
//  Sits between the CPU-COP interface and the FU array; the generated decoder (external,
//  combinational on enc_q) supplies dec_fu_sel / dec_invalid_opcode / dec_arg_crd.
// PARAMETERS
//  NFU      4    number of functional units (one-hot select width)
//  TIMEOUT  255  max cycles in WAIT before forced ABORT (8-bit counter, 1..255)
// PORTS
//  g_clk              in   1       clock
//  g_resetn           in   1       asynchronous active-low reset
//  cpu_insn_req       in   1       CPU presents instruction
//  cpu_insn_ack       out  1       instruction accepted (1-cycle pulse)
//  cpu_insn_enc       in   32      instruction encoding
//  cpu_insn_rs1       in   32      GPR rs1 value
//  cpu_abort          in   1       CPU requests abort of in-flight instruction
//  enc_q              out  32      latched encoding, drives external decoder
//  dec_fu_sel         in   NFU     one-hot FU select for enc_q
//  dec_invalid_opcode in   1       enc_q is not a valid COP instruction
//  dec_arg_crd        in   4       destination CPR index
//  fu_req             out  NFU     one-hot dispatch request (held until fu_done)
//  fu_rs1             out  32      latched rs1 to FUs
//  fu_done            in   NFU     FU completion strobe (1 cycle)
//  fu_result          in   3*NFU   per-FU result code
//  fu_cpr_wen         in   NFU     per-FU CPR write enable
//  fu_cpr_wdata       in   32*NFU  per-FU CPR write data
//  fu_gpr_wen         in   NFU     per-FU GPR write enable
//  fu_gpr_wdata       in   32*NFU  per-FU GPR write data
//  cpr_wen            out  1       CPR file write strobe
//  cpr_waddr          out  4       CPR write index
//  cpr_wdata          out  32      CPR write data
//  cpu_rsp_valid      out  1       result valid to CPU
//  cpu_rsp_ack        in   1       CPU accepts result
//  cpu_rsp_result     out  3       result code
//  cpu_rsp_wen        out  1       GPR write enable
//  cpu_rsp_wdata      out  32      GPR write data
// BEHAVIOUR
//  Result codes: SUCCESS=0 ABORT=1 BAD_INS=2 BAD_LAD=3 BAD_SAD=4 LD_ERR=5 ST_ERR=6; no other emitted.
//  Reset: state=IDLE; every output 0; enc_q, fu_rs1, rsp regs and timer cleared.
//  IDLE: on cpu_insn_req -> latch enc/rs1, pulse cpu_insn_ack, -> DECODE.
//  DECODE (1 cycle): dec_invalid_opcode or dec_fu_sel not one-hot -> RESP with BAD_INS, wen=0;
//   else -> WAIT, fu_req=dec_fu_sel registered, timer=0.
//  WAIT: fu_req held. fu_done from selected FU -> capture result/gpr; cpr_wen pulses same edge
//   only if fu_cpr_wen && result==SUCCESS (addr=dec_arg_crd, data=fu_cpr_wdata); -> RESP.
//   fu_done from non-selected FU ignored. FU result==BAD_INS remapped to ABORT.
//   cpu_abort or timer==TIMEOUT -> drop fu_req, result=ABORT, wen=0, no CPR write, -> RESP.
//   fu_done and cpu_abort same cycle: fu_done wins (instruction completes normally).
//  RESP: cpu_rsp_valid=1, outputs stable until cpu_rsp_ack; ack -> IDLE next cycle.
//   cpu_rsp_wen forced 0 for any result != SUCCESS. cpu_insn_ack never asserted outside IDLE.
//  Latency: min 4 cycles req-to-rsp_valid (IDLE,DECODE,WAIT w/ same-cycle done,RESP).
//  Async reset mid-instruction: all state dropped, fu_req=0 immediately, no response issued.
// TESTING
//  mv2cop enc, rs1=0xDEADBEEF, FU0 done SUCCESS cpr_wen crd=3 -> cpr_wen 1 cyc addr3 data DEADBEEF, result 0, rsp_wen 0.
//  Invalid enc (dec_invalid_opcode=1) -> no fu_req, result 2, rsp_wen 0, CPR untouched.
//  FU never completes, TIMEOUT=8 -> fu_req drops after 8 WAIT cycles, result 1, no CPR write.
//  cpu_abort and fu_done same cycle -> result from FU (0), CPR written.
//  FU2 returns LD_ERR(5) with gpr_wen=1 -> result 5, rsp_wen 0, no CPR write.
//  cpu_rsp_ack held low 10 cycles then new cpu_insn_req -> rsp stable, new insn acked only after return to IDLE.

Source files
------------

// File: rtl/scarv_cop_insn_seq.sv
// scarv_cop_insn_seq: accepts one COP instruction at a time, dispatches it to a single FU,
// collects that FU's completion, commits the CPR write and returns a result code to the CPU.
module scarv_cop_insn_seq #(
    parameter int NFU     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               cpu_insn_req,
    output logic               cpu_insn_ack,
    input  logic [31:0]        cpu_insn_enc,
    input  logic [31:0]        cpu_insn_rs1,
    input  logic               cpu_abort,
    output logic [31:0]        enc_q,
    input  logic [NFU-1:0]     dec_fu_sel,
    input  logic               dec_invalid_opcode,
    input  logic [3:0]         dec_arg_crd,
    output logic [NFU-1:0]     fu_req,
    output logic [31:0]        fu_rs1,
    input  logic [NFU-1:0]     fu_done,
    input  logic [3*NFU-1:0]   fu_result,
    input  logic [NFU-1:0]     fu_cpr_wen,
    input  logic [32*NFU-1:0]  fu_cpr_wdata,
    input  logic [NFU-1:0]     fu_gpr_wen,
    input  logic [32*NFU-1:0]  fu_gpr_wdata,
    output logic               cpr_wen,
    output logic [3:0]         cpr_waddr,
    output logic [31:0]        cpr_wdata,
    output logic               cpu_rsp_valid,
    input  logic               cpu_rsp_ack,
    output logic [2:0]         cpu_rsp_result,
    output logic               cpu_rsp_wen,
    output logic [31:0]        cpu_rsp_wdata
);
    localparam logic [2:0] RES_SUCCESS = 3'd0;
    localparam logic [2:0] RES_ABORT   = 3'd1;
    localparam logic [2:0] RES_BAD_INS = 3'd2;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_RESP} state_t;

    state_t          state_q;
    logic [NFU-1:0]  fu_req_q;
    logic [31:0]     fu_rs1_q;
    logic [7:0]      timer_q;
    logic            cpr_wen_q;
    logic [3:0]      cpr_waddr_q;
    logic [31:0]     cpr_wdata_q;
    logic            rsp_valid_q;
    logic [2:0]      rsp_result_q;
    logic            rsp_wen_q;
    logic [31:0]     rsp_wdata_q;

    logic [2:0]      sel_result;
    logic            sel_cpr_wen;
    logic [31:0]     sel_cpr_wdata;
    logic            sel_gpr_wen;
    logic [31:0]     sel_gpr_wdata;
    logic            done_hit;
    logic            fu_ok;
    logic [2:0]      fu_code;
    logic            sel_onehot;
    logic            timed_out;

    // fu_req_q is one-hot while waiting, so OR-ing the masked lanes selects the active FU
    always_comb begin
        sel_result    = '0;
        sel_cpr_wen   = 1'b0;
        sel_cpr_wdata = '0;
        sel_gpr_wen   = 1'b0;
        sel_gpr_wdata = '0;
        for (int i = 0; i < NFU; i++) begin
            sel_result    |= fu_req_q[i] ? fu_result[3*i +: 3]     : 3'd0;
            sel_cpr_wen   |= fu_req_q[i] & fu_cpr_wen[i];
            sel_cpr_wdata |= fu_req_q[i] ? fu_cpr_wdata[32*i +: 32] : 32'd0;
            sel_gpr_wen   |= fu_req_q[i] & fu_gpr_wen[i];
            sel_gpr_wdata |= fu_req_q[i] ? fu_gpr_wdata[32*i +: 32] : 32'd0;
        end
    end

    assign done_hit   = |(fu_done & fu_req_q);
    assign fu_ok      = sel_result == RES_SUCCESS;
    // BAD_INS from an FU and the unused code 7 are reported to the CPU as ABORT
    assign fu_code    = (sel_result == RES_BAD_INS || sel_result == 3'd7) ? RES_ABORT : sel_result;
    assign sel_onehot = (dec_fu_sel != '0) && ((dec_fu_sel & (dec_fu_sel - NFU'(1))) == '0);
    // timer_q counts completed WAIT cycles; the abort lands on the edge ending the TIMEOUT-th
    assign timed_out  = timer_q == 8'(TIMEOUT - 1);

    assign cpu_insn_ack   = (state_q == S_IDLE) && cpu_insn_req;
    assign fu_req         = fu_req_q;
    assign fu_rs1         = fu_rs1_q;
    assign cpr_wen        = cpr_wen_q;
    assign cpr_waddr      = cpr_waddr_q;
    assign cpr_wdata      = cpr_wdata_q;
    assign cpu_rsp_valid  = rsp_valid_q;
    assign cpu_rsp_result = rsp_result_q;
    assign cpu_rsp_wen    = rsp_wen_q;
    assign cpu_rsp_wdata  = rsp_wdata_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q      <= S_IDLE;
            enc_q        <= '0;
            fu_rs1_q     <= '0;
            fu_req_q     <= '0;
            timer_q      <= '0;
            cpr_wen_q    <= 1'b0;
            cpr_waddr_q  <= '0;
            cpr_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_wen_q    <= 1'b0;
            rsp_wdata_q  <= '0;
        end else begin
            cpr_wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_insn_req) begin
                        enc_q    <= cpu_insn_enc;
                        fu_rs1_q <= cpu_insn_rs1;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_invalid_opcode || !sel_onehot) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= RES_BAD_INS;
                        rsp_wen_q    <= 1'b0;
                        rsp_wdata_q  <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        fu_req_q <= dec_fu_sel;
                        timer_q  <= '0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_hit) begin
                        fu_req_q     <= '0;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= fu_code;
                        rsp_wen_q    <= sel_gpr_wen && fu_ok;
                        rsp_wdata_q  <= (sel_gpr_wen && fu_ok) ? sel_gpr_wdata : 32'd0;
                        cpr_wen_q    <= sel_cpr_wen && fu_ok;
                        if (sel_cpr_wen && fu_ok) begin
                            cpr_waddr_q <= dec_arg_crd;
                            cpr_wdata_q <= sel_cpr_wdata;
                        end
                        state_q      <= S_RESP;
                    end else if (cpu_abort || timed_out) begin
                        fu_req_q     <= '0;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= RES_ABORT;
                        rsp_wen_q    <= 1'b0;
                        rsp_wdata_q  <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (cpu_rsp_ack) begin
                        rsp_valid_q  <= 1'b0;
                        rsp_result_q <= '0;
                        rsp_wen_q    <= 1'b0;
                        rsp_wdata_q  <= '0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scarv_cop_insn_seq.sv
// tb_scarv_cop_insn_seq: directed instructions against a transaction-level model of the sequencer,
// checked every cycle, plus hand-computed literals for the headline scenarios.
module tb_scarv_cop_insn_seq;
    localparam int NFU = 4;
    localparam int TO  = 8;

    logic               g_clk = 1'b0;
    logic               g_resetn = 1'b0;
    logic               cpu_insn_req = 1'b0;
    logic               cpu_insn_ack;
    logic [31:0]        cpu_insn_enc = '0;
    logic [31:0]        cpu_insn_rs1 = '0;
    logic               cpu_abort = 1'b0;
    logic [31:0]        enc_q;
    logic [NFU-1:0]     dec_fu_sel;
    logic               dec_invalid_opcode;
    logic [3:0]         dec_arg_crd;
    logic [NFU-1:0]     fu_req;
    logic [31:0]        fu_rs1;
    logic [NFU-1:0]     fu_done = '0;
    logic [3*NFU-1:0]   fu_result = '0;
    logic [NFU-1:0]     fu_cpr_wen = '0;
    logic [32*NFU-1:0]  fu_cpr_wdata = '0;
    logic [NFU-1:0]     fu_gpr_wen = '0;
    logic [32*NFU-1:0]  fu_gpr_wdata = '0;
    logic               cpr_wen;
    logic [3:0]         cpr_waddr;
    logic [31:0]        cpr_wdata;
    logic               cpu_rsp_valid;
    logic               cpu_rsp_ack = 1'b0;
    logic [2:0]         cpu_rsp_result;
    logic               cpu_rsp_wen;
    logic [31:0]        cpu_rsp_wdata;

    scarv_cop_insn_seq #(.NFU(NFU), .TIMEOUT(TO)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_insn_rs1(cpu_insn_rs1), .cpu_abort(cpu_abort),
        .enc_q(enc_q), .dec_fu_sel(dec_fu_sel), .dec_invalid_opcode(dec_invalid_opcode),
        .dec_arg_crd(dec_arg_crd), .fu_req(fu_req), .fu_rs1(fu_rs1), .fu_done(fu_done),
        .fu_result(fu_result), .fu_cpr_wen(fu_cpr_wen), .fu_cpr_wdata(fu_cpr_wdata),
        .fu_gpr_wen(fu_gpr_wen), .fu_gpr_wdata(fu_gpr_wdata),
        .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr), .cpr_wdata(cpr_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ack(cpu_rsp_ack),
        .cpu_rsp_result(cpu_rsp_result), .cpu_rsp_wen(cpu_rsp_wen), .cpu_rsp_wdata(cpu_rsp_wdata)
    );

    always #5 g_clk = ~g_clk;

    // Toy decoder: bit31 invalid, bit30 raw select in [7:4], else FU index in [1:0]; crd in [11:8]
    assign dec_invalid_opcode = enc_q[31];
    assign dec_fu_sel         = enc_q[30] ? enc_q[7:4] : 4'b0001 << enc_q[1:0];
    assign dec_arg_crd        = enc_q[11:8];

    int n_chk = 0;
    int n_fail = 0;

    logic [NFU-1:0] exp_fu_req = '0;
    logic           exp_valid = 1'b0;
    logic [2:0]     exp_result = '0;
    logic           exp_wen = 1'b0;
    logic [31:0]    exp_wdata = '0;
    logic           exp_cpr_wen = 1'b0;
    logic [3:0]     exp_cpr_waddr = '0;
    logic [31:0]    exp_cpr_wdata = '0;
    logic           exp_idle = 1'b1;
    logic [31:0]    exp_enc = '0;
    logic [31:0]    exp_rs1 = '0;

    int             cpr_count = 0;
    int             req_cycles = 0;
    logic [3:0]     last_waddr = '0;
    logic [31:0]    last_wdata = '0;
    logic [2:0]     last_result = '0;
    logic           last_wen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge g_clk);
        #1;
        chk("fu_req", fu_req, exp_fu_req);
        chk("rsp_valid", cpu_rsp_valid, exp_valid);
        chk("cpr_wen", cpr_wen, exp_cpr_wen);
        chk("insn_ack", cpu_insn_ack, exp_idle && cpu_insn_req);
        chk("enc_q", enc_q, exp_enc);
        chk("fu_rs1", fu_rs1, exp_rs1);
        if (exp_valid) begin
            chk("rsp_result", cpu_rsp_result, exp_result);
            chk("rsp_wen", cpu_rsp_wen, exp_wen);
            if (exp_wen) chk("rsp_wdata", cpu_rsp_wdata, exp_wdata);
        end
        if (exp_cpr_wen) begin
            chk("cpr_waddr", cpr_waddr, exp_cpr_waddr);
            chk("cpr_wdata", cpr_wdata, exp_cpr_wdata);
        end
        if (cpr_wen) begin
            cpr_count++;
            last_waddr = cpr_waddr;
            last_wdata = cpr_wdata;
        end
        if (cpu_rsp_valid) begin
            last_result = cpu_rsp_result;
            last_wen    = cpu_rsp_wen;
        end
        if (fu_req != '0) req_cycles++;
    end

    // One instruction: done_at/abort_at are WAIT-cycle indices (-1 = never).
    // Non-selected FUs present SUCCESS with writes enabled and a stray done, all of which must be ignored.
    task automatic run(input logic [31:0] enc, input logic [31:0] rs1, input int done_at,
                       input logic [2:0] res, input logic cw, input logic [31:0] cd,
                       input logic gw, input logic [31:0] gd, input int abort_at,
                       input int ack_delay, input logic req_in_resp);
        logic [3:0] sel;
        int         idx;
        logic       bad;
        int         cand;
        logic       by_done;
        logic       by_abort;
        sel      = enc[30] ? enc[7:4] : 4'b0001 << enc[1:0];
        idx      = int'(enc[1:0]);
        bad      = enc[31] || ($countones(sel) != 1);
        cand     = TO - 1;
        by_done  = 1'b0;
        by_abort = 1'b0;
        if (abort_at >= 0 && abort_at < cand) begin
            cand     = abort_at;
            by_abort = 1'b1;
        end
        if (done_at >= 0 && done_at <= cand) begin
            cand    = done_at;
            by_done = 1'b1;
        end
        @(negedge g_clk);
        cpu_rsp_ack  = 1'b0;
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        cpu_insn_rs1 = rs1;
        exp_idle     = 1'b0;
        exp_enc      = enc;
        exp_rs1      = rs1;
        #1 chk("ack_in_idle", cpu_insn_ack, 1'b1);
        @(negedge g_clk);
        cpu_insn_req = 1'b0;
        for (int i = 0; i < NFU; i++) begin
            fu_result[3*i +: 3]     = (i == idx) ? res : 3'd0;
            fu_cpr_wen[i]           = (i == idx) ? cw : 1'b1;
            fu_cpr_wdata[32*i +: 32] = (i == idx) ? cd : ~cd;
            fu_gpr_wen[i]           = (i == idx) ? gw : 1'b1;
            fu_gpr_wdata[32*i +: 32] = (i == idx) ? gd : ~gd;
        end
        if (bad) begin
            exp_valid  = 1'b1;
            exp_result = 3'd2;
            exp_wen    = 1'b0;
        end else begin
            exp_fu_req = sel;
            for (int k = 0; k <= cand; k++) begin
                @(negedge g_clk);
                fu_done   = '0;
                cpu_abort = 1'b0;
                if (k == 0 && done_at != 0) fu_done = ~sel;
                if (k == done_at) fu_done = sel;
                if (k == abort_at) cpu_abort = 1'b1;
                if (k == cand) begin
                    exp_fu_req    = '0;
                    exp_valid     = 1'b1;
                    exp_result    = by_done ? ((res == 3'd2 || res == 3'd7) ? 3'd1 : res) : 3'd1;
                    exp_wen       = by_done && res == 3'd0 && gw;
                    exp_wdata     = gd;
                    exp_cpr_wen   = by_done && res == 3'd0 && cw;
                    exp_cpr_waddr = enc[11:8];
                    exp_cpr_wdata = cd;
                end
            end
        end
        for (int j = 0; j < ack_delay; j++) begin
            @(negedge g_clk);
            exp_cpr_wen = 1'b0;
            fu_done     = '0;
            cpu_abort   = 1'b0;
            if (req_in_resp) cpu_insn_req = 1'b1;
        end
        @(negedge g_clk);
        exp_cpr_wen = 1'b0;
        fu_done     = '0;
        cpu_abort   = 1'b0;
        cpu_rsp_ack = 1'b1;
        exp_valid   = 1'b0;
        exp_idle    = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge g_clk);
        chk("reset_fu_req", fu_req, 0);
        chk("reset_rsp_valid", cpu_rsp_valid, 0);
        chk("reset_cpr_wen", cpr_wen, 0);
        chk("reset_enc_q", enc_q, 0);
        chk("reset_insn_ack", cpu_insn_ack, 0);
        g_resetn = 1'b1;

        // mv2cop into CPR 3 from FU0
        run(32'h0000_0300, 32'hDEADBEEF, 0, 3'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, -1, 1, 1'b0);
        chk("t1_cpr_count", cpr_count, 1);
        chk("t1_cpr_waddr", last_waddr, 4'd3);
        chk("t1_cpr_wdata", last_wdata, 32'hDEADBEEF);
        chk("t1_result", last_result, 3'd0);
        chk("t1_rsp_wen", last_wen, 1'b0);

        req_cycles = 0;
        run(32'h8000_0003, 32'h1234_5678, 0, 3'd0, 1'b1, 32'h1, 1'b1, 32'h2, -1, 0, 1'b0);
        chk("t2_result", last_result, 3'd2);
        chk("t2_no_fu_req", req_cycles, 0);
        chk("t2_cpr_count", cpr_count, 1);
        run(32'h4000_0030, 32'h0, 0, 3'd0, 1'b1, 32'h1, 1'b0, 32'h0, -1, 0, 1'b0);
        chk("t2b_twohot_result", last_result, 3'd2);
        run(32'h4000_0000, 32'h0, 0, 3'd0, 1'b1, 32'h1, 1'b0, 32'h0, -1, 0, 1'b0);
        chk("t2c_nosel_result", last_result, 3'd2);

        req_cycles = 0;
        run(32'h0000_0501, 32'h0000_0042, -1, 3'd0, 1'b1, 32'h7, 1'b0, 32'h0, -1, 0, 1'b0);
        chk("t3_req_cycles", req_cycles, 8);
        chk("t3_result", last_result, 3'd1);
        chk("t3_cpr_count", cpr_count, 1);

        run(32'h0000_0703, 32'hCAFEF00D, 2, 3'd0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0000_1234, 2, 0, 1'b0);
        chk("t4_result", last_result, 3'd0);
        chk("t4_cpr_count", cpr_count, 2);
        chk("t4_cpr_waddr", last_waddr, 4'd7);
        chk("t4_rsp_wen", last_wen, 1'b1);

        run(32'h0000_0202, 32'h0000_0099, 1, 3'd5, 1'b1, 32'h5555_0000, 1'b1, 32'hAAAA_0000, -1, 2, 1'b0);
        chk("t5_result", last_result, 3'd5);
        chk("t5_rsp_wen", last_wen, 1'b0);
        chk("t5_cpr_count", cpr_count, 2);

        req_cycles = 0;
        run(32'h0000_0101, 32'h0000_0001, 5, 3'd0, 1'b1, 32'h9, 1'b0, 32'h0, 3, 0, 1'b0);
        chk("t7_abort_result", last_result, 3'd1);
        chk("t7_req_cycles", req_cycles, 4);
        chk("t7_cpr_count", cpr_count, 2);

        run(32'h0000_0F00, 32'h0000_0002, 0, 3'd2, 1'b1, 32'hB, 1'b1, 32'hC, -1, 0, 1'b0);
        chk("t8_remap_result", last_result, 3'd1);
        chk("t8_cpr_count", cpr_count, 2);

        // response held 10 cycles with the next request already waiting
        run(32'h0000_0401, 32'h1111_2222, 1, 3'd0, 1'b0, 32'h0, 1'b1, 32'hABCD_0001, -1, 10, 1'b1);
        chk("t6_result", last_result, 3'd0);
        chk("t6_rsp_wen", last_wen, 1'b1);
        run(32'h0000_0900, 32'h55AA_55AA, 0, 3'd0, 1'b1, 32'h55AA_55AA, 1'b0, 32'h0, -1, 0, 1'b0);
        chk("t6_next_cpr_count", cpr_count, 3);
        chk("t6_next_cpr_waddr", last_waddr, 4'd9);

        // async reset while waiting on FU1
        @(negedge g_clk);
        cpu_rsp_ack  = 1'b0;
        cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'h0000_0601;
        cpu_insn_rs1 = 32'h0BAD_F00D;
        exp_idle     = 1'b0;
        exp_enc      = 32'h0000_0601;
        exp_rs1      = 32'h0BAD_F00D;
        @(negedge g_clk);
        cpu_insn_req = 1'b0;
        exp_fu_req   = 4'b0010;
        @(negedge g_clk);
        #2;
        g_resetn   = 1'b0;
        exp_fu_req = '0;
        exp_enc    = '0;
        exp_rs1    = '0;
        exp_idle   = 1'b1;
        #1;
        chk("t9_async_fu_req", fu_req, 0);
        chk("t9_async_enc_q", enc_q, 0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        repeat (3) @(negedge g_clk);
        chk("t9_no_rsp", cpu_rsp_valid, 0);
        chk("t9_cpr_count", cpr_count, 3);

        run(32'h0000_0A02, 32'h0000_0777, 3, 3'd0, 1'b1, 32'h0000_0777, 1'b0, 32'h0, -1, 1, 1'b0);
        chk("t10_result", last_result, 3'd0);
        chk("t10_cpr_waddr", last_waddr, 4'hA);
        chk("t10_cpr_count", cpr_count, 4);

        @(negedge g_clk);
        cpu_rsp_ack = 1'b0;
        repeat (2) @(negedge g_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
